// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM datapath: ALU ops, mux selects,
// flag positions and the immediate extender.
package arm_mc_pkg;

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluAnd = 2'b10,
        AluOrr = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ImmDp   = 2'b00,
        ImmMem  = 2'b01,
        ImmBr   = 2'b10,
        ImmZero = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        SrcAReg    = 2'b00,
        SrcAPc     = 2'b01,
        SrcAAluOut = 2'b10,
        SrcAZero   = 2'b11
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SrcBReg  = 2'b00,
        SrcBImm  = 2'b01,
        SrcBFour = 2'b10,
        SrcBZero = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ResAluOut    = 2'b00,
        ResData      = 2'b01,
        ResAluResult = 2'b10,
        ResZero      = 2'b11
    } result_src_t;

    localparam logic [3:0] PC_REG = 4'd15;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Data-processing immediates ignore the rotate field; branch offsets are word-scaled.
    function automatic logic [31:0] extendImm(imm_src_t src, logic [23:0] imm);
        logic [31:0] ext;
        unique case (src)
            ImmDp:   ext = {24'd0, imm[7:0]};
            ImmMem:  ext = {20'd0, imm[11:0]};
            ImmBr:   ext = {{6{imm[23]}}, imm, 2'b00};
            default: ext = 32'd0;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/arm_mc_datapath_if.sv
// Control word, feedback and memory port between controller and datapath.
interface arm_mc_datapath_if;
    logic        PCWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
    logic [31:0] ReadData;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;

    modport master (
        output PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ImmSrc, ALUControl, ReadData,
        input  Adr, WriteData, Instr, ALUFlags
    );

    modport slave (
        input  PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ImmSrc, ALUControl, ReadData,
        output Adr, WriteData, Instr, ALUFlags
    );
endinterface

// File: rtl/arm_regfile.sv
// 15-entry register file; R15 is supplied from outside and never stored.
module arm_regfile
    import arm_mc_pkg::*;
(
    input  logic        clk,
    input  logic        we3,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    input  logic [3:0]  wa3,
    input  logic [31:0] wd3,
    input  logic [31:0] r15,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs [0:14];

    // Synchronous write; writes aimed at R15 are dropped.
    always_ff @(posedge clk) begin
        if (we3 && (wa3 != PC_REG)) begin
            regs[wa3] <= wd3;
        end
    end

    // Asynchronous reads, R15 bypassed from the external value.
    always_comb begin
        rd1 = (ra1 == PC_REG) ? r15 : regs[ra1];
        rd2 = (ra2 == PC_REG) ? r15 : regs[ra2];
    end
endmodule

// File: rtl/arm_mc_datapath.sv
// Multicycle ARM datapath: PC, IR, operand/result registers, extender, ALU and muxes.
module arm_mc_datapath
    import arm_mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    arm_mc_datapath_if.slave bus
);
    logic [31:0] pcQ, irQ, dataQ, aQ, bQ, aluOutQ;
    logic [31:0] rd1, rd2, extImm, srcA, srcB, srcBAdj, aluResult, result;
    logic [32:0] sum;
    logic [3:0]  ra1, ra2, aluFlags;
    logic        carry, overflow, isSub;

    alu_op_t     aluOp;
    alu_src_a_t  srcASel;
    alu_src_b_t  srcBSel;
    result_src_t resSel;

    assign aluOp   = alu_op_t'(bus.ALUControl);
    assign srcASel = alu_src_a_t'(bus.ALUSrcA);
    assign srcBSel = alu_src_b_t'(bus.ALUSrcB);
    assign resSel  = result_src_t'(bus.ResultSrc);

    // Architectural and pipeline-style holding registers; reset wins over any write enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcQ     <= 32'd0;
            irQ     <= 32'd0;
            dataQ   <= 32'd0;
            aQ      <= 32'd0;
            bQ      <= 32'd0;
            aluOutQ <= 32'd0;
        end else begin
            if (bus.PCWrite) pcQ <= result;
            if (bus.IRWrite) irQ <= bus.ReadData;
            dataQ   <= bus.ReadData;
            aQ      <= rd1;
            bQ      <= rd2;
            aluOutQ <= aluResult;
        end
    end

    // Register-file address selection and immediate extension.
    always_comb begin
        ra1    = bus.RegSrc[0] ? PC_REG : irQ[19:16];
        ra2    = bus.RegSrc[1] ? irQ[15:12] : irQ[3:0];
        extImm = extendImm(imm_src_t'(bus.ImmSrc), irQ[23:0]);
    end

    arm_regfile uRegfile (
        .clk (clk),
        .we3 (bus.RegWrite && !reset),
        .ra1 (ra1),
        .ra2 (ra2),
        .wa3 (irQ[15:12]),
        .wd3 (result),
        .r15 (result),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // ALU source muxes, ALU and flag generation; SUB reuses the adder as A + ~B + 1.
    always_comb begin
        unique case (srcASel)
            SrcAReg:    srcA = aQ;
            SrcAPc:     srcA = pcQ;
            SrcAAluOut: srcA = aluOutQ;
            default:    srcA = 32'd0;
        endcase
        unique case (srcBSel)
            SrcBReg:  srcB = bQ;
            SrcBImm:  srcB = extImm;
            SrcBFour: srcB = 32'd4;
            default:  srcB = 32'd0;
        endcase

        isSub    = (aluOp == AluSub);
        srcBAdj  = isSub ? ~srcB : srcB;
        sum      = {1'b0, srcA} + {1'b0, srcBAdj} + {32'd0, isSub};
        carry    = 1'b0;
        overflow = 1'b0;

        unique case (aluOp)
            AluAdd, AluSub: begin
                aluResult = sum[31:0];
                carry     = sum[32];
                overflow  = (srcA[31] == srcBAdj[31]) && (sum[31] != srcA[31]);
            end
            AluAnd:  aluResult = srcA & srcB;
            default: aluResult = srcA | srcB;
        endcase

        aluFlags         = 4'd0;
        aluFlags[FLAG_N] = aluResult[31];
        aluFlags[FLAG_Z] = (aluResult == 32'd0);
        aluFlags[FLAG_C] = carry;
        aluFlags[FLAG_V] = overflow;
    end

    // Result mux feeding PC, register file, R15 reads and the memory address.
    always_comb begin
        unique case (resSel)
            ResAluOut:    result = aluOutQ;
            ResData:      result = dataQ;
            ResAluResult: result = aluResult;
            default:      result = 32'd0;
        endcase
    end

    assign bus.Adr       = bus.AdrSrc ? result : pcQ;
    assign bus.WriteData = bQ;
    assign bus.Instr     = irQ[31:12];
    assign bus.ALUFlags  = aluFlags;
endmodule
